// File: rtl/text_box_addr_gen.sv
// ----------------------------------------------------------------------------
// text_box_addr_gen
//
// Text-overlay address generator. Maps the VGA beam onto a COLS x ROWS grid
// of 8x16 glyphs whose top-left corner is at (BOX_X, BOX_Y). Each cell's
// code comes from an internal writable text RAM. The block emits a font-ROM
// address {code[6:0], line[3:0]} plus the pixel column inside the glyph. Bit 7
// of a cell is a blink attribute: while blink_phase is set, a blinking cell
// shows a space (0x20) instead of its code.
//
// After reset the text RAM is filled with spaces, one cell per cycle. Host
// writes are refused during that fill and accepted afterwards.
//
// Ports
//   clk_i            pixel clock
//   rst_ni           asynchronous reset, active low
//   vga_*_i          beam timing from upstream (hcount, vcount, syncs, blanks)
//   vga_*_o          vga_*_i delayed 2 cycles, aligned with char_addr_o
//   wr_en_i          text RAM write request
//   wr_addr_i        cell index = row*COLS+col (indices >= DEPTH are dropped)
//   wr_char_i        [7] blink attribute, [6:0] character code
//   wr_ready_o       1 = a write request in this cycle is accepted
//   char_addr_o      font ROM address {code, line}; 0 outside the box
//   char_col_o       pixel column inside the glyph; 0 outside the box
//   char_valid_o     beam inside the box, aligned with char_addr_o
//
// Text RAM fill state machine
//   state   | meaning
//   CLEAR   | writing 0x20 to cell clr_ptr_q, host writes refused
//   RUN     | host writes accepted, stays here until reset
// ----------------------------------------------------------------------------
module text_box_addr_gen #(
    parameter int BOX_X        = 280,
    parameter int BOX_Y        = 104,
    parameter int COLS         = 16,
    parameter int ROWS         = 4,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic [10:0]         vga_hcount_i,
    input  logic [10:0]         vga_vcount_i,
    input  logic                vga_hsync_i,
    input  logic                vga_vsync_i,
    input  logic                vga_hblnk_i,
    input  logic                vga_vblnk_i,

    output logic [10:0]         vga_hcount_o,
    output logic [10:0]         vga_vcount_o,
    output logic                vga_hsync_o,
    output logic                vga_vsync_o,
    output logic                vga_hblnk_o,
    output logic                vga_vblnk_o,

    input  logic                wr_en_i,
    input  logic [$clog2(COLS*ROWS):0] wr_addr_i,
    input  logic [7:0]          wr_char_i,
    output logic                wr_ready_o,

    output logic [10:0]         char_addr_o,
    output logic [2:0]          char_col_o,
    output logic                char_valid_o
);

    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;
    localparam int DEPTH  = COLS * ROWS;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // The write address carries one extra bit so that indices at or beyond
    // DEPTH are representable and can be dropped instead of aliasing.
    localparam int WAW    = $clog2(DEPTH) + 1;
    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Box limits held one bit wider than the beam counters so the inclusive
    // right/bottom edge never wraps.
    localparam logic [11:0] X_LO = 12'(BOX_X);
    localparam logic [11:0] X_HI = 12'(BOX_X + COLS * CHAR_W - 1);
    localparam logic [11:0] Y_LO = 12'(BOX_Y);
    localparam logic [11:0] Y_HI = 12'(BOX_Y + ROWS * CHAR_H - 1);

    localparam logic [AW-1:0]  CLR_LAST   = AW'(DEPTH - 1);
    localparam logic [WAW-1:0] WR_LIMIT   = WAW'(DEPTH);
    localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [7:0]     SPACE      = 8'h20;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_ptr_q, clr_ptr_d;

    logic            ram_we;
    logic [AW-1:0]   ram_waddr;
    logic [7:0]      ram_wdata;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      rd_data_q;
    logic [AW-1:0]   rd_addr;

    logic [10:0]     h_off, v_off;
    logic            in_box_d;
    logic [CW-1:0]   col_d;
    logic [RW-1:0]   row_d;
    logic [3:0]      line_d;
    logic [2:0]      pix_d;

    logic            in_box1_q, in_box2_q;
    logic [CW-1:0]   col1_q;
    logic [RW-1:0]   row1_q;
    logic [3:0]      line1_q, line2_q;
    logic [2:0]      pix1_q, pix2_q;

    logic [10:0]     hcount1_q, vcount1_q, hcount2_q, vcount2_q;
    logic [3:0]      sync1_q, sync2_q;

    logic            frame_tick;
    logic [BW-1:0]   blink_cnt_q;
    logic            blink_phase_q;
    logic [6:0]      code;

    // ------------------------------------------------------------------
    // Fill FSM and write-port arbitration
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        ram_wdata  = '0;
        wr_ready_o = 1'b0;
        case (state_q)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_ptr_q;
                ram_wdata = SPACE;
                if (clr_ptr_q == CLR_LAST) begin
                    state_d   = RUN;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            RUN: begin
                wr_ready_o = 1'b1;
                // Out-of-range indices are accepted (wr_ready=1) but dropped.
                if (wr_en_i && (wr_addr_i < WR_LIMIT)) begin
                    ram_we    = 1'b1;
                    ram_waddr = AW'(wr_addr_i);
                    ram_wdata = wr_char_i;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Text RAM: one write port, one synchronous read port, read-first on a
    // same-address collision (the read sees the previous contents).
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            mem_q[ram_waddr] <= ram_wdata;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_addr = AW'(int'(row1_q) * COLS + int'(col1_q));

    // ------------------------------------------------------------------
    // Stage 1: box test and glyph coordinates
    // ------------------------------------------------------------------
    assign h_off = vga_hcount_i - X_LO[10:0];
    assign v_off = vga_vcount_i - Y_LO[10:0];

    always_comb begin
        in_box_d = ({1'b0, vga_hcount_i} >= X_LO) && ({1'b0, vga_hcount_i} <= X_HI) &&
                   ({1'b0, vga_vcount_i} >= Y_LO) && ({1'b0, vga_vcount_i} <= Y_HI);
        col_d  = '0;
        row_d  = '0;
        line_d = '0;
        pix_d  = '0;
        // Coordinates are zeroed outside the box so the RAM read index
        // always stays in range.
        if (in_box_d) begin
            col_d  = CW'(h_off >> 3);
            row_d  = RW'(v_off >> 4);
            line_d = v_off[3:0];
            pix_d  = h_off[2:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_box1_q <= 1'b0;
            col1_q    <= '0;
            row1_q    <= '0;
            line1_q   <= '0;
            pix1_q    <= '0;
            in_box2_q <= 1'b0;
            line2_q   <= '0;
            pix2_q    <= '0;
            hcount1_q <= '0;
            vcount1_q <= '0;
            sync1_q   <= '0;
            hcount2_q <= '0;
            vcount2_q <= '0;
            sync2_q   <= '0;
        end else begin
            in_box1_q <= in_box_d;
            col1_q    <= col_d;
            row1_q    <= row_d;
            line1_q   <= line_d;
            pix1_q    <= pix_d;
            in_box2_q <= in_box1_q;
            line2_q   <= line1_q;
            pix2_q    <= pix1_q;
            hcount1_q <= vga_hcount_i;
            vcount1_q <= vga_vcount_i;
            sync1_q   <= {vga_hsync_i, vga_vsync_i, vga_hblnk_i, vga_vblnk_i};
            hcount2_q <= hcount1_q;
            vcount2_q <= vcount1_q;
            sync2_q   <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Blink timer: one tick per frame, phase flips every BLINK_FRAMES ticks
    // ------------------------------------------------------------------
    assign frame_tick = (vga_hcount_i == 11'd0) && (vga_vcount_i == 11'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 outputs
    // ------------------------------------------------------------------
    assign code = (rd_data_q[7] && blink_phase_q) ? SPACE[6:0] : rd_data_q[6:0];

    assign char_addr_o  = in_box2_q ? {code, line2_q} : 11'd0;
    assign char_col_o   = in_box2_q ? pix2_q : 3'd0;
    assign char_valid_o = in_box2_q;

    assign vga_hcount_o = hcount2_q;
    assign vga_vcount_o = vcount2_q;
    assign vga_hsync_o  = sync2_q[3];
    assign vga_vsync_o  = sync2_q[2];
    assign vga_hblnk_o  = sync2_q[1];
    assign vga_vblnk_o  = sync2_q[0];

endmodule

// File: tb/tb_text_box_addr_gen.sv
module tb_text_box_addr_gen;

    logic        clk;
    logic        rst_n;
    logic [10:0] hcount, vcount;
    logic        hsync, vsync, hblnk, vblnk;
    logic [10:0] hcount_o, vcount_o;
    logic        hsync_o, vsync_o, hblnk_o, vblnk_o;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_char;
    logic        wr_ready;
    logic [10:0] char_addr;
    logic [2:0]  char_col;
    logic        char_valid;

    int checks   = 0;
    int failures = 0;
    int n;

    text_box_addr_gen dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .vga_hcount_i (hcount),
        .vga_vcount_i (vcount),
        .vga_hsync_i  (hsync),
        .vga_vsync_i  (vsync),
        .vga_hblnk_i  (hblnk),
        .vga_vblnk_i  (vblnk),
        .vga_hcount_o (hcount_o),
        .vga_vcount_o (vcount_o),
        .vga_hsync_o  (hsync_o),
        .vga_vsync_o  (vsync_o),
        .vga_hblnk_o  (hblnk_o),
        .vga_vblnk_o  (vblnk_o),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_char_i    (wr_char),
        .wr_ready_o   (wr_ready),
        .char_addr_o  (char_addr),
        .char_col_o   (char_col),
        .char_valid_o (char_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_beam();
        hcount = 11'd1000;
        vcount = 11'd1000;
    endtask

    // Put the beam on a cell/line/pixel and advance through the 2-cycle pipe.
    task automatic beam_cell(input int col, input int row, input int line, input int pix);
        hcount = 11'(280 + col * 8 + pix);
        vcount = 11'(104 + row * 16 + line);
        step();
        step();
    endtask

    task automatic beam_at(input int h, input int v);
        hcount = 11'(h);
        vcount = 11'(v);
        step();
        step();
    endtask

    task automatic write_cell(input int addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = 7'(addr);
        wr_char = data;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic frame_ticks(input int count);
        for (int i = 0; i < count; i++) begin
            hcount = 11'd0;
            vcount = 11'd0;
            step();
        end
        idle_beam();
    endtask

    initial begin
        rst_n   = 1'b0;
        hsync   = 1'b0;
        vsync   = 1'b0;
        hblnk   = 1'b0;
        vblnk   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_char = '0;
        idle_beam();

        // Reset values
        #12;
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_char_addr", 32'(char_addr), 32'd0);
        chk("rst_valid", 32'(char_valid), 32'd0);
        step();
        step();
        chk("rst_hcount_o", 32'(hcount_o), 32'd0);
        chk("rst_char_col", 32'(char_col), 32'd0);

        // Fill phase lasts exactly DEPTH cycles
        rst_n = 1'b1;
        n = 0;
        while (wr_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("clear_len", 32'(n), 32'd64);

        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 16; c++) begin
                beam_cell(c, r, c, c % 8);
                chk("clear_cell", 32'(char_addr), (32'h20 << 4) | 32'(c));
            end
        end
        idle_beam();

        // Write 'A' to cell 0 and read it back at line 5
        write_cell(0, 8'h41);
        hsync = 1'b1;
        beam_cell(0, 0, 5, 0);
        chk("a_char_addr", 32'(char_addr), 32'h415);
        chk("a_char_col", 32'(char_col), 32'd0);
        chk("a_valid", 32'(char_valid), 32'd1);
        chk("a_hcount_o", 32'(hcount_o), 32'd280);
        chk("a_vcount_o", 32'(vcount_o), 32'd109);
        chk("a_hsync_o", 32'(hsync_o), 32'd1);
        hsync = 1'b0;
        beam_cell(0, 0, 9, 5);
        chk("a_pix5_addr", 32'(char_addr), 32'h419);
        chk("a_pix5_col", 32'(char_col), 32'd5);

        // Box edges
        beam_at(407, 167);
        chk("edge_br_valid", 32'(char_valid), 32'd1);
        chk("edge_br_addr", 32'(char_addr), 32'h20F);
        chk("edge_br_col", 32'(char_col), 32'd7);
        beam_at(408, 167);
        chk("edge_h408_valid", 32'(char_valid), 32'd0);
        chk("edge_h408_addr", 32'(char_addr), 32'd0);
        chk("edge_h408_col", 32'(char_col), 32'd0);
        beam_at(280, 168);
        chk("edge_v168_valid", 32'(char_valid), 32'd0);
        chk("edge_v168_addr", 32'(char_addr), 32'd0);
        beam_at(279, 104);
        chk("edge_h279_valid", 32'(char_valid), 32'd0);
        chk("edge_h279_addr", 32'(char_addr), 32'd0);
        beam_at(280, 103);
        chk("edge_v103_valid", 32'(char_valid), 32'd0);
        beam_at(280, 104);
        chk("edge_tl_addr", 32'(char_addr), 32'h410);
        idle_beam();

        // Blink attribute on cell 1
        write_cell(1, 8'hC1);
        beam_cell(1, 0, 3, 2);
        chk("blink_ph0", 32'(char_addr), 32'h413);
        idle_beam();
        frame_ticks(29);
        beam_cell(1, 0, 3, 2);
        chk("blink_29", 32'(char_addr), 32'h413);
        idle_beam();
        frame_ticks(1);
        beam_cell(1, 0, 3, 2);
        chk("blink_30", 32'(char_addr), 32'h203);
        beam_cell(0, 0, 5, 0);
        chk("blink_noattr", 32'(char_addr), 32'h415);
        idle_beam();
        frame_ticks(30);
        beam_cell(1, 0, 3, 2);
        chk("blink_60", 32'(char_addr), 32'h413);
        idle_beam();

        // Out-of-range writes are accepted but dropped
        write_cell(64, 8'h55);
        write_cell(127, 8'h56);
        chk("oor_ready", 32'(wr_ready), 32'd1);
        beam_cell(0, 0, 5, 0);
        chk("oor_cell0", 32'(char_addr), 32'h415);
        idle_beam();

        // Same-cycle write and read of cell 5: read-first
        hcount = 11'd320;
        vcount = 11'd106;
        step();
        wr_en   = 1'b1;
        wr_addr = 7'd5;
        wr_char = 8'h42;
        step();
        wr_en = 1'b0;
        chk("rw_old", 32'(char_addr), 32'h202);
        step();
        chk("rw_new", 32'(char_addr), 32'h422);
        idle_beam();

        // Reset in the middle of a line with a write pending
        beam_cell(0, 0, 5, 0);
        chk("pre_rst_addr", 32'(char_addr), 32'h415);
        wr_en   = 1'b1;
        wr_addr = 7'd0;
        wr_char = 8'h43;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_addr", 32'(char_addr), 32'd0);
        chk("midrst_valid", 32'(char_valid), 32'd0);
        chk("midrst_hcount_o", 32'(hcount_o), 32'd0);
        chk("midrst_ready", 32'(wr_ready), 32'd0);
        step();
        wr_en = 1'b0;
        rst_n = 1'b1;
        n = 0;
        while (wr_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("reclear_len", 32'(n), 32'd64);
        beam_cell(0, 0, 5, 0);
        chk("reclear_cell0", 32'(char_addr), 32'h205);
        beam_cell(1, 0, 3, 0);
        chk("reclear_cell1", 32'(char_addr), 32'h203);
        beam_cell(5, 0, 2, 0);
        chk("reclear_cell5", 32'(char_addr), 32'h202);
        idle_beam();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
